multiplier_rr_scheduler: RTL
============================

// Module: multiplier_rr_scheduler
// PURPOSE
//  Shares one 4-bit shift-add multiplier (St/Mplier/Mcand in, Done/Result out) among NREQ requesters.
//  Picks a requester round-robin, issues St, holds the operands, captures Result on Done and returns it.
//  Sits between client blocks and a single multiplier instance in the arithmetic subsystem.
// PARAMETERS
//  NREQ        4   number of requesters (2..8)
//  WIDTH       4   operand width; the product is 2*WIDTH
//  SETTLE_CYC  10  idle cycles after reset before the first St (drains a multiplier that has no reset)
//  TIMEOUT_CYC 12  maximum cycles in WAIT before the operation is aborted
// PORTS
//  Clk         in   1             rising-edge clock shared with the multiplier
//  Rst_n       in   1             asynchronous, active-low reset
//  Req         in   NREQ          level request per client; held until its Ack
//  Req_Mplier  in   NREQ*WIDTH    client i multiplier at [i*WIDTH +: WIDTH]
//  Req_Mcand   in   NREQ*WIDTH    client i multiplicand, same packing
//  Ack         out  NREQ          one-hot, one-cycle completion pulse
//  Ack_Result  out  2*WIDTH       product; valid only while Ack != 0
//  Ack_Err     out  1             with Ack: timeout abort, Ack_Result = 0
//  Busy        out  1             high in every state except IDLE
//  Mul_St      out  1             start strobe to the multiplier
//  Mul_Mplier  out  WIDTH         operand held from START through WAIT
//  Mul_Mcand   out  WIDTH         operand held from START through WAIT
//  Mul_Done    in   1             multiplier done (one cycle)
//  Mul_Result  in   2*WIDTH       multiplier product, valid with Mul_Done
// BEHAVIOUR
//  Reset (async, Rst_n=0): state=SETTLE, counter=0, rr pointer=NREQ-1, all outputs 0 (Busy=1 in SETTLE).
//  FSM SETTLE -> IDLE -> START -> WAIT -> ACK -> IDLE.
//  SETTLE: count SETTLE_CYC cycles, ignore Req, Mul_St=0, then go to IDLE.
//  IDLE: if Req!=0, grant the first set bit scanning upward from pointer+1 (mod NREQ).
//    Latch the grant index and that client's operands; go to START. Otherwise stay.
//  START: exactly one cycle, Mul_St=1; operands are registered (not muxed live from Req_*); go to WAIT.
//  WAIT: Mul_St=0; operands held stable (the multiplier reads Mcand every add step); count cycles.
//    Mul_Done=1 -> capture Mul_Result and go to ACK.
//    Count reaches TIMEOUT_CYC -> set err flag, result=0, go to SETTLE-after-ACK.
//  ACK: one cycle. Ack[grant]=1, Ack_Result=captured result, Ack_Err=err; pointer<=grant.
//    Then go to IDLE, or to SETTLE if err.
//  Latency: Req seen in IDLE at cycle t -> Mul_St at t+1 -> Mul_Done between t+6 (Mplier=0) and t+10 (Mplier=F).
//    Ack follows 1 cycle after Mul_Done.
//  Req changes after grant are ignored; the operation completes and Ack pulses anyway.
//  The client drops Req the cycle after Ack; Req still high in the next IDLE is a new request.
//  Mul_Done outside WAIT is ignored. Mul_Done in the same cycle the timeout count hits is treated as success.
//  Requests arriving during START/WAIT/ACK wait; there is no queueing beyond the level Req.
//  Fairness: any continuously asserted Req is granted within NREQ operations.
//  Rst_n asserted mid-operation: everything clears immediately; the multiplier drains during SETTLE.
//    No Ack for the aborted operation.
//  Arithmetic: none in the product path; counters are clog2(max(SETTLE_CYC,TIMEOUT_CYC)+1) bits and saturate.
// STRUCTURE
//  Package mul_sched_pkg: state localparams (SETTLE=0, IDLE=1, START=2, WAIT=3, ACK=4) and default timing constants.
//  Sub-module rr_arbiter #(NREQ): combinational req + pointer -> one-hot grant + index.
//    Also reused by other shared-unit schedulers.
//  Everything else is a single FSM, one counter and the operand/result registers in this module.
// TESTING (bench instantiates a real multiplier_shiftAdd_4bit behind the scheduler)
//  1 Reset, Req=0001 at cycle 2 -> no Mul_St before SETTLE ends (cycle 10); then one Ack[0].
//  2 Client0 5x3 -> Ack=0001, Ack_Result=8'h0F, Ack_Err=0; F x F -> 8'hE1 at t+11; 0 x 9 -> 8'h00 at t+7.
//  3 Req=1111 held, operands i*3 x 2 -> Acks in order 0,1,2,3,0 with results 0,6,C,12; no client starved.
//  4 Mul_Done tied 0 -> after 12 WAIT cycles Ack=grant, Ack_Err=1, Ack_Result=0; then SETTLE, then normal service.
//  5 Rst_n pulsed low mid-WAIT -> Ack/Mul_St=0 immediately; next Req served correctly after SETTLE (e.g. 7x6=8'h2A).
//  6 Client changes Req_Mcand during WAIT -> result uses the latched operand (2x3=6, not 2x9).

Source files
------------

// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared types and default timing for the multiplier scheduler
package mul_sched_pkg;

    // Scheduler states; the encoding values are fixed so waveforms read the same across builds
    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ACK    = 3'd4
    } sched_state_e;

    localparam int DEF_NREQ        = 4;
    localparam int DEF_WIDTH       = 4;
    localparam int DEF_SETTLE_CYC  = 10;
    localparam int DEF_TIMEOUT_CYC = 12;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, grants first request above the pointer
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            grant_valid
);

    // Scan upward starting one past the last winner, wrapping modulo NREQ; first hit wins
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!grant_valid && req[idx]) begin
                grant_valid    = 1'b1;
                grant_idx      = IW'(idx);
                grant[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multiplier_rr_scheduler.sv
// rtl/multiplier_rr_scheduler.sv - shares one shift-add multiplier among NREQ clients round-robin
module multiplier_rr_scheduler
    import mul_sched_pkg::*;
#(
    parameter int NREQ        = DEF_NREQ,
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [NREQ-1:0]       Req,
    input  logic [NREQ*WIDTH-1:0] Req_Mplier,
    input  logic [NREQ*WIDTH-1:0] Req_Mcand,
    output logic [NREQ-1:0]       Ack,
    output logic [2*WIDTH-1:0]    Ack_Result,
    output logic                  Ack_Err,
    output logic                  Busy,
    output logic                  Mul_St,
    output logic [WIDTH-1:0]      Mul_Mplier,
    output logic [WIDTH-1:0]      Mul_Mcand,
    input  logic                  Mul_Done,
    input  logic [2*WIDTH-1:0]    Mul_Result
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(max_int(SETTLE_CYC, TIMEOUT_CYC) + 1);

    sched_state_e         state_q,  state_d;
    logic [CW-1:0]        cnt_q,    cnt_d;
    logic [IW-1:0]        ptr_q,    ptr_d;
    logic [IW-1:0]        grant_q,  grant_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q,  mcand_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 err_q,    err_d;

    logic [NREQ-1:0]      arb_grant;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;
    logic [CW-1:0]        cnt_inc;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req         (Req),
        .ptr         (ptr_q),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    // Shared cycle counter never wraps, so a stuck state cannot alias back to a small count
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    // Next-state logic: settle after reset/abort, grant, strobe, wait for done or timeout, acknowledge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_SETTLE: begin
                if (cnt_q >= CW'(SETTLE_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_d  = arb_idx;
                    mplier_d = Req_Mplier[int'(arb_idx)*WIDTH +: WIDTH];
                    mcand_d  = Req_Mcand[int'(arb_idx)*WIDTH +: WIDTH];
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                cnt_d    = '0;
                err_d    = 1'b0;
                result_d = '0;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                // Done wins over a simultaneous timeout: the product is valid, so use it
                if (Mul_Done) begin
                    result_d = Mul_Result;
                    err_d    = 1'b0;
                    state_d  = ST_ACK;
                end else if (cnt_q >= CW'(TIMEOUT_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_ACK;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ACK: begin
                ptr_d   = grant_q;
                cnt_d   = '0;
                // After an abort the multiplier may still be mid-operation; let it drain first
                state_d = err_q ? ST_SETTLE : ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation without an Ack
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= '0;
            ptr_q    <= IW'(NREQ - 1);
            grant_q  <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from registered state; operands come from the latch, never live from Req_*
    always_comb begin
        Ack        = '0;
        Ack_Result = '0;
        Ack_Err    = 1'b0;
        Busy       = (state_q != ST_IDLE);
        Mul_St     = (state_q == ST_START);
        Mul_Mplier = mplier_q;
        Mul_Mcand  = mcand_q;
        if (state_q == ST_ACK) begin
            Ack        = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;
            Ack_Result = result_q;
            Ack_Err    = err_q;
        end
    end

endmodule
